// File: rtl/alu_register_unit_if.sv
// ---------------------------------------------------------------------------
// alu_register_unit_if
// Bus between the control FSM and the ALU/register datapath slice.
//   master : the control FSM. It drives the write and output enables, the
//            load data, the opcode and the carry-in. It reads the outputs.
//   slave  : alu_register_unit. It drives t1_out, t2_out, alu_out and
//            alu_flags.
// Signals:
//   t1_we/t1_oe/t1_in/t1_out : load, drive and data for operand register T1
//   t2_we/t2_oe/t2_in/t2_out : the same for T2
//   alu_oe/alu_opcode/alu_carry/alu_out/alu_flags : ALU control and result
//   alu_flags = {parity, overflow, sign, zero, carry}
// ---------------------------------------------------------------------------
interface alu_register_unit_if #(
    parameter int WIDTH = 32
);
    logic             t1_we;
    logic             t1_oe;
    logic [WIDTH-1:0] t1_in;
    logic [WIDTH-1:0] t1_out;
    logic             t2_we;
    logic             t2_oe;
    logic [WIDTH-1:0] t2_in;
    logic [WIDTH-1:0] t2_out;
    logic             alu_oe;
    logic [3:0]       alu_opcode;
    logic             alu_carry;
    logic [WIDTH-1:0] alu_out;
    logic [4:0]       alu_flags;

    modport master (
        output t1_we, t1_oe, t1_in, t2_we, t2_oe, t2_in,
        output alu_oe, alu_opcode, alu_carry,
        input  t1_out, t2_out, alu_out, alu_flags
    );

    modport slave (
        input  t1_we, t1_oe, t1_in, t2_we, t2_oe, t2_in,
        input  alu_oe, alu_opcode, alu_carry,
        output t1_out, t2_out, alu_out, alu_flags
    );
endinterface

// File: rtl/alu_register_unit.sv
// ---------------------------------------------------------------------------
// alu_register_unit
// Arithmetic core of the CPU. Two operand registers (T1, T2) feed a purely
// combinational ALU. The control FSM loads the operands with write enables.
// It gates them onto the outputs with output enables. It reads the result
// and the flags in the same cycle.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset. Clears both registers and
//            takes priority over the write enables.
//   dbg_en : present only when ALU_REG_DEBUG_EN is defined. While it is
//            high, simulation prints the register, result and flag values
//            at each rising edge.
//   bus    : alu_register_unit_if.slave, which carries the enables, the
//            data and the ALU controls and results.
//
// Opcodes:
//    0 ADD    1 ADC    2 SUB    3 SBB
//    4 AND    5 OR     6 XOR    7 NOT
//    8 SHL    9 SHR   10 SAR   11 ROL
//   12 ROR   13 INC   14 DEC   15 PASS
// alu_flags = {parity, overflow, sign, zero, carry}
//
// Optional feature macro: ALU_REG_DEBUG_EN
// ---------------------------------------------------------------------------

// One operand register with gated (non-tri-state) read port.
module alu_reg_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             oe,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (we)
            q <= din;
    end

    // The read port shows the stored value, so a write in the same cycle
    // does not appear until after the edge.
    assign dout = oe ? q : '0;
endmodule

module alu_register_unit #(
    parameter int WIDTH = 32,
    parameter int FLAGS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ALU_REG_DEBUG_EN
    input  logic                  dbg_en,
`endif
    alu_register_unit_if.slave    bus
);
    localparam int MSB = WIDTH - 1;
    localparam int SW  = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB  = 4'd3,
        OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT  = 4'd7,
        OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_ROL  = 4'd11,
        OP_ROR = 4'd12, OP_INC = 4'd13, OP_DEC = 4'd14, OP_PASS = 4'd15
    } alu_op_e;

    // ---------------- operand registers ----------------
    logic [1:0]            r_we, r_oe;
    logic [1:0][WIDTH-1:0] r_din, r_q, r_dout;

    assign r_we  = {bus.t2_we, bus.t1_we};
    assign r_oe  = {bus.t2_oe, bus.t1_oe};
    assign r_din = {bus.t2_in, bus.t1_in};

    for (genvar g = 0; g < 2; g++) begin : g_reg
        alu_reg_slice #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .we   (r_we[g]),
            .oe   (r_oe[g]),
            .din  (r_din[g]),
            .q    (r_q[g]),
            .dout (r_dout[g])
        );
    end

    assign bus.t1_out = r_dout[0];
    assign bus.t2_out = r_dout[1];

    // ---------------- ALU ----------------
    // The operands are the gated values, so a register that is not
    // enabled reads as zero.
    logic [WIDTH-1:0] a, b;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   cin_ext, one_ext;

    assign a       = r_dout[0];
    assign b       = r_dout[1];
    assign sh      = b[SW-1:0];
    assign cin_ext = {{WIDTH{1'b0}}, bus.alu_carry};
    assign one_ext = {{WIDTH{1'b0}}, 1'b1};

    // Each shift is done on a word one bit wider than the operand. The
    // extra bit catches the last bit shifted out. For a shift of zero it
    // stays 0, so no special case is needed.
    logic [WIDTH:0]          shl_ext, shr_ext;
    logic signed [WIDTH:0]   sar_ext;
    logic [2*WIDTH-1:0]      rol_ext, ror_ext;

    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sar_ext = $signed({a, 1'b0}) >>> sh;
    // Rotating a doubled word: the upper half gives ROL, the lower half ROR.
    assign rol_ext = {a, a} << sh;
    assign ror_ext = {a, a} >> sh;

    logic [WIDTH-1:0] res;
    logic             cy, ov;
    logic [FLAGS-1:0] flags;

    always_comb begin
        res = '0;
        cy  = 1'b0;
        ov  = 1'b0;
        case (alu_op_e'(bus.alu_opcode))
            OP_ADD: begin
                {cy, res} = {1'b0, a} + {1'b0, b};
                ov = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_ADC: begin
                {cy, res} = {1'b0, a} + {1'b0, b} + cin_ext;
                ov = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            // For subtraction the top bit of the wide difference is the
            // borrow: it is 1 when A is smaller than the subtrahend, unsigned.
            OP_SUB: begin
                {cy, res} = {1'b0, a} - {1'b0, b};
                ov = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SBB: begin
                {cy, res} = {1'b0, a} - {1'b0, b} - cin_ext;
                ov = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL: begin
                res = shl_ext[WIDTH-1:0];
                cy  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res = shr_ext[WIDTH:1];
                cy  = shr_ext[0];
            end
            OP_SAR: begin
                res = sar_ext[WIDTH:1];
                cy  = sar_ext[0];
            end
            OP_ROL: begin
                res = rol_ext[2*WIDTH-1:WIDTH];
                cy  = (sh != '0) && res[0];
            end
            OP_ROR: begin
                res = ror_ext[WIDTH-1:0];
                cy  = (sh != '0) && res[MSB];
            end
            OP_INC: begin
                {cy, res} = {1'b0, a} + one_ext;
                ov = !a[MSB] && res[MSB];
            end
            OP_DEC: begin
                {cy, res} = {1'b0, a} - one_ext;
                ov = a[MSB] && !res[MSB];
            end
            OP_PASS: res = a;
            default: res = '0;
        endcase
    end

    // The flags come from the result before the alu_oe gate, so they stay
    // valid while the output is disabled.
    assign flags = {~^res, ov, res[MSB], (res == '0), cy};

    assign bus.alu_out   = bus.alu_oe ? res : '0;
    assign bus.alu_flags = flags;

`ifdef ALU_REG_DEBUG_EN
    always @(posedge clk) begin
        if (dbg_en)
            $display("alu_register_unit dbg: t1=%0d (0x%h) t2=%0d (0x%h) alu_out=%0d (0x%h) flags=0x%h",
                     r_q[0], r_q[0], r_q[1], r_q[1], bus.alu_out, bus.alu_out, flags);
    end
`endif
endmodule

// File: tb/tb_alu_register_unit.sv
// Directed bench for alu_register_unit. The expected values are worked out
// by hand for the default WIDTH of 32. Flags are {parity, overflow, sign,
// zero, carry}.
module tb_alu_register_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    alu_register_unit_if #(.WIDTH(32)) bus ();

    alu_register_unit #(.WIDTH(32), .FLAGS(5)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef ALU_REG_DEBUG_EN
        .dbg_en (1'b0),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes both registers on one edge, then leaves both write enables low.
    task automatic load(input logic [31:0] v1, input logic [31:0] v2);
        bus.t1_in = v1; bus.t2_in = v2;
        bus.t1_we = 1'b1; bus.t2_we = 1'b1;
        tick();
        bus.t1_we = 1'b0; bus.t2_we = 1'b0;
    endtask

    task automatic test_reset();
        bus.t1_we = 0; bus.t2_we = 0; bus.t1_oe = 0; bus.t2_oe = 0;
        bus.t1_in = '0; bus.t2_in = '0;
        bus.alu_oe = 0; bus.alu_opcode = 4'd0; bus.alu_carry = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.t1_out !== 32'd0) begin n_bad++; $display("FAIL reset_t1_out got %h want 0", bus.t1_out); end
        n_vec++; if (bus.t2_out !== 32'd0) begin n_bad++; $display("FAIL reset_t2_out got %h want 0", bus.t2_out); end
        n_vec++; if (bus.alu_out !== 32'd0) begin n_bad++; $display("FAIL reset_alu_out got %h want 0", bus.alu_out); end
        n_vec++; if (bus.alu_flags !== 5'b10010) begin n_bad++; $display("FAIL reset_flags got %b want 10010", bus.alu_flags); end
        bus.t1_oe = 1; bus.t2_oe = 1; bus.alu_oe = 1;
        #1;
        n_vec++; if (bus.alu_out !== 32'd0 || bus.t1_out !== 32'd0 || bus.t2_out !== 32'd0) begin
            n_bad++; $display("FAIL reset_regs_enabled got %h/%h/%h want 0", bus.t1_out, bus.t2_out, bus.alu_out);
        end
    endtask

    task automatic test_basic_add();
        load(32'd5, 32'd6);
        bus.t1_oe = 1; bus.t2_oe = 1; bus.alu_oe = 1; bus.alu_opcode = 4'd0; bus.alu_carry = 0;
        #1;
        n_vec++; if (bus.t1_out !== 32'd5) begin n_bad++; $display("FAIL basic_t1_out got %0d want 5", bus.t1_out); end
        n_vec++; if (bus.t2_out !== 32'd6) begin n_bad++; $display("FAIL basic_t2_out got %0d want 6", bus.t2_out); end
        n_vec++; if (bus.alu_out !== 32'd11 || bus.alu_flags !== 5'b00000) begin
            n_bad++; $display("FAIL basic_add got %0d/%b want 11/00000", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd1; bus.alu_carry = 1;
        #1;
        n_vec++; if (bus.alu_out !== 32'd12 || bus.alu_flags !== 5'b10000) begin
            n_bad++; $display("FAIL basic_adc got %0d/%b want 12/10000", bus.alu_out, bus.alu_flags);
        end
        bus.alu_carry = 0;
    endtask

    task automatic test_arith();
        load(32'hFFFF_FFFF, 32'd1); bus.alu_opcode = 4'd0; #1;
        n_vec++; if (bus.alu_out !== 32'd0 || bus.alu_flags !== 5'b10011) begin
            n_bad++; $display("FAIL add_wrap got %h/%b want 0/10011", bus.alu_out, bus.alu_flags);
        end
        load(32'h7FFF_FFFF, 32'd1); bus.alu_opcode = 4'd0; #1;
        n_vec++; if (bus.alu_out !== 32'h8000_0000 || bus.alu_flags !== 5'b01100) begin
            n_bad++; $display("FAIL add_ovf got %h/%b want 80000000/01100", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd13; #1;
        n_vec++; if (bus.alu_out !== 32'h8000_0000 || bus.alu_flags !== 5'b01100) begin
            n_bad++; $display("FAIL inc_ovf got %h/%b want 80000000/01100", bus.alu_out, bus.alu_flags);
        end
        load(32'd3, 32'd5); bus.alu_opcode = 4'd2; #1;
        n_vec++; if (bus.alu_out !== 32'hFFFF_FFFE || bus.alu_flags !== 5'b00101) begin
            n_bad++; $display("FAIL sub_borrow got %h/%b want fffffffe/00101", bus.alu_out, bus.alu_flags);
        end
        load(32'd5, 32'd5); bus.alu_opcode = 4'd3; bus.alu_carry = 1; #1;
        n_vec++; if (bus.alu_out !== 32'hFFFF_FFFF || bus.alu_flags !== 5'b10101) begin
            n_bad++; $display("FAIL sbb got %h/%b want ffffffff/10101", bus.alu_out, bus.alu_flags);
        end
        bus.alu_carry = 0;
        load(32'd0, 32'd0); bus.alu_opcode = 4'd14; #1;
        n_vec++; if (bus.alu_out !== 32'hFFFF_FFFF || bus.alu_flags !== 5'b10101) begin
            n_bad++; $display("FAIL dec_zero got %h/%b want ffffffff/10101", bus.alu_out, bus.alu_flags);
        end
        load(32'h8000_0000, 32'd0); #1;
        n_vec++; if (bus.alu_out !== 32'h7FFF_FFFF || bus.alu_flags !== 5'b01000) begin
            n_bad++; $display("FAIL dec_ovf got %h/%b want 7fffffff/01000", bus.alu_out, bus.alu_flags);
        end
    endtask

    task automatic test_logic();
        load(32'hF0F0_00FF, 32'h0FF0_0F0F);
        bus.alu_opcode = 4'd4; #1;
        n_vec++; if (bus.alu_out !== 32'h00F0_000F || bus.alu_flags !== 5'b10000) begin
            n_bad++; $display("FAIL and got %h/%b want 00f0000f/10000", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd5; #1;
        n_vec++; if (bus.alu_out !== 32'hFFF0_0FFF || bus.alu_flags !== 5'b10100) begin
            n_bad++; $display("FAIL or got %h/%b want fff00fff/10100", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd6; #1;
        n_vec++; if (bus.alu_out !== 32'hFF00_0FF0 || bus.alu_flags !== 5'b10100) begin
            n_bad++; $display("FAIL xor got %h/%b want ff000ff0/10100", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd7; #1;
        n_vec++; if (bus.alu_out !== 32'h0F0F_FF00 || bus.alu_flags !== 5'b10000) begin
            n_bad++; $display("FAIL not got %h/%b want 0f0fff00/10000", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd15; #1;
        n_vec++; if (bus.alu_out !== 32'hF0F0_00FF || bus.alu_flags !== 5'b10100) begin
            n_bad++; $display("FAIL pass got %h/%b want f0f000ff/10100", bus.alu_out, bus.alu_flags);
        end
    endtask

    task automatic test_shift();
        load(32'h8000_0001, 32'd1);
        bus.alu_opcode = 4'd8; #1;
        n_vec++; if (bus.alu_out !== 32'h0000_0002 || bus.alu_flags !== 5'b00001) begin
            n_bad++; $display("FAIL shl got %h/%b want 00000002/00001", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd9; #1;
        n_vec++; if (bus.alu_out !== 32'h4000_0000 || bus.alu_flags !== 5'b00001) begin
            n_bad++; $display("FAIL shr got %h/%b want 40000000/00001", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd10; #1;
        n_vec++; if (bus.alu_out !== 32'hC000_0000 || bus.alu_flags !== 5'b10101) begin
            n_bad++; $display("FAIL sar got %h/%b want c0000000/10101", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd11; #1;
        n_vec++; if (bus.alu_out !== 32'h0000_0003 || bus.alu_flags !== 5'b10001) begin
            n_bad++; $display("FAIL rol got %h/%b want 00000003/10001", bus.alu_out, bus.alu_flags);
        end
        bus.alu_opcode = 4'd12; #1;
        n_vec++; if (bus.alu_out !== 32'hC000_0000 || bus.alu_flags !== 5'b10101) begin
            n_bad++; $display("FAIL ror got %h/%b want c0000000/10101", bus.alu_out, bus.alu_flags);
        end
        // The shift amount is B[4:0]. Here the amount is 0, and B[5] must be
        // ignored.
        load(32'h8000_0001, 32'h20);
        bus.alu_opcode = 4'd8; #1;
        n_vec++; if (bus.alu_out !== 32'h8000_0001 || bus.alu_flags !== 5'b10100) begin
            n_bad++; $display("FAIL shl_zero_amt got %h/%b want 80000001/10100", bus.alu_out, bus.alu_flags);
        end
        load(32'h8000_0001, 32'h24);
        bus.alu_opcode = 4'd9; #1;
        n_vec++; if (bus.alu_out !== 32'h0800_0000 || bus.alu_flags !== 5'b00000) begin
            n_bad++; $display("FAIL shr_by4 got %h/%b want 08000000/00000", bus.alu_out, bus.alu_flags);
        end
    endtask

    task automatic test_gating();
        load(32'd5, 32'd3);
        bus.t1_oe = 0; bus.t2_oe = 1; bus.alu_oe = 1; bus.alu_opcode = 4'd15; #1;
        n_vec++; if (bus.t1_out !== 32'd0) begin n_bad++; $display("FAIL gate_t1_out got %h want 0", bus.t1_out); end
        n_vec++; if (bus.alu_out !== 32'd0 || bus.alu_flags !== 5'b10010) begin
            n_bad++; $display("FAIL gate_pass got %h/%b want 0/10010", bus.alu_out, bus.alu_flags);
        end
        bus.t1_oe = 1; bus.alu_oe = 0; #1;
        n_vec++; if (bus.alu_out !== 32'd0 || bus.alu_flags !== 5'b10000) begin
            n_bad++; $display("FAIL gate_alu_oe got %h/%b want 0/10000", bus.alu_out, bus.alu_flags);
        end
        bus.alu_oe = 1; #1;
        n_vec++; if (bus.alu_out !== 32'd5) begin n_bad++; $display("FAIL gate_alu_on got %h want 5", bus.alu_out); end
    endtask

    task automatic test_reset_priority();
        bus.t1_oe = 1; bus.t2_oe = 1;
        load(32'd7, 32'd4);
        rst = 1; bus.t1_we = 1; bus.t1_in = 32'd9;
        tick();
        rst = 0; bus.t1_we = 0; #1;
        n_vec++; if (bus.t1_out !== 32'd0 || bus.t2_out !== 32'd0) begin
            n_bad++; $display("FAIL rst_over_we got %h/%h want 0/0", bus.t1_out, bus.t2_out);
        end
        load(32'd7, 32'd0);
        bus.t1_in = 32'd8; bus.t1_we = 1; #1;
        n_vec++; if (bus.t1_out !== 32'd7) begin n_bad++; $display("FAIL no_write_through got %0d want 7", bus.t1_out); end
        tick();
        bus.t1_we = 0; #1;
        n_vec++; if (bus.t1_out !== 32'd8) begin n_bad++; $display("FAIL write_after_edge got %0d want 8", bus.t1_out); end
    endtask

    task automatic test_back_to_back();
        bus.t1_oe = 1; bus.t2_oe = 1; bus.alu_oe = 1; bus.alu_opcode = 4'd0;
        bus.t1_we = 1; bus.t2_we = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.t1_in = 32'(i * 100);
            bus.t2_in = 32'(i);
            tick();
            n_vec++; if (bus.alu_out !== 32'(i * 101)) begin
                n_bad++; $display("FAIL b2b_%0d got %0d want %0d", i, bus.alu_out, i * 101);
            end
        end
        bus.t1_we = 0; bus.t2_we = 0;
        bus.t1_in = 32'd999; tick();
        n_vec++; if (bus.alu_out !== 32'd303) begin n_bad++; $display("FAIL b2b_hold got %0d want 303", bus.alu_out); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_arith();
        test_logic();
        test_shift();
        test_gating();
        test_reset_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
